// File: rtl/freq_pkg.sv
// Shared types, constants and helpers for the frequency-step front end.
package freq_pkg;
   localparam int LVL_W = 3;
   localparam int DIV_W = 8;
   localparam int N_LVL = 2 ** LVL_W;
   localparam logic [LVL_W-1:0] LVL_MAX = '1;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} fsm_state_e;
   typedef enum logic [1:0] {NONE, UP, DOWN} btn_code_e;

   localparam logic [DIV_W-1:0] DIV_TABLE [N_LVL] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
   };

   // Both buttons held together is deliberately read as "released".
   function automatic btn_code_e btn_code(input logic up, input logic dn);
      btn_code_e code;
      code = NONE;
      if (up && !dn) begin
         code = UP;
      end else if (dn && !up) begin
         code = DOWN;
      end
      return code;
   endfunction

   function automatic logic [LVL_W-1:0] step_level(input logic [LVL_W-1:0] lvl,
                                                   input btn_code_e code);
      logic [LVL_W-1:0] nxt;
      nxt = lvl;
      if (code == UP && lvl != LVL_MAX) begin
         nxt = lvl + 1'b1;
      end else if (code == DOWN && lvl != '0) begin
         nxt = lvl - 1'b1;
      end
      return nxt;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one push-button.
module btn_debounce #(
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 26
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_i,
   output logic deb_o
);
   localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             deb_q;
   logic [CNT_W-1:0] cnt_q;

   // Any return to the accepted level restarts the stability count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         if (sync2_q != deb_q) begin
            if (cnt_q == DEB_TC) begin
               deb_q <= sync2_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign deb_o = deb_q;
endmodule

// File: rtl/freq_step_ctrl.sv
// Button-driven frequency level stepper; hands the divisor to the divider only at its terminal count.
module freq_step_ctrl
   import freq_pkg::*;
#(
   parameter int DEB_CYCLES   = 500000,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 20000000,
   parameter int CNT_W        = 26
) (
   input  logic             CLKNEXYS,
   input  logic             reset,
   input  logic             aumf_i,
   input  logic             bajaf_i,
   input  logic             tc_i,
   output logic [DIV_W-1:0] div_o,
   output logic [LVL_W-1:0] valueF,
   output logic             pend_o,
   output logic             upd_o
);
   // state  | meaning
   // IDLE   | no button held, waiting for a press
   // HOLD   | stepped once, timing the hold before auto-repeat
   // REPEAT | auto-repeating at the repeat rate while held

   localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_TC = CNT_W'(REPEAT_RATE - 1);

   logic             deb_up;
   logic             deb_dn;
   btn_code_e        code;
   fsm_state_e       state_q;
   btn_code_e        code_q;
   logic [CNT_W-1:0] timer_q;
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] level_d;
   logic             pend_q;
   logic [DIV_W-1:0] div_q;
   logic [LVL_W-1:0] val_q;
   logic             upd_q;
   logic             step_req;
   logic             lvl_chg;
   logic             commit;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_up (
      .clk_i   (CLKNEXYS),
      .rst_n_i (reset),
      .btn_i   (aumf_i),
      .deb_o   (deb_up)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_dn (
      .clk_i   (CLKNEXYS),
      .rst_n_i (reset),
      .btn_i   (bajaf_i),
      .deb_o   (deb_dn)
   );

   assign code = btn_code(deb_up, deb_dn);

   always_comb begin
      step_req = 1'b0;
      if (code != NONE) begin
         case (state_q)
            IDLE:    step_req = 1'b1;
            HOLD:    step_req = (code != code_q) || (timer_q == DLY_TC);
            REPEAT:  step_req = (code != code_q) || (timer_q == RATE_TC);
            default: step_req = 1'b0;
         endcase
      end
   end

   assign level_d = step_req ? step_level(level_q, code) : level_q;
   assign lvl_chg = (level_d != level_q);
   // Commit samples the level before this cycle's step; a same-cycle step stays pending.
   assign commit  = pend_q & tc_i;

   always_ff @(posedge CLKNEXYS or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         code_q  <= NONE;
         timer_q <= '0;
         level_q <= '0;
         pend_q  <= 1'b0;
         div_q   <= DIV_TABLE[0];
         val_q   <= '0;
         upd_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         upd_q   <= commit;
         if (commit) begin
            div_q  <= DIV_TABLE[level_q];
            val_q  <= level_q;
            pend_q <= lvl_chg;
         end else if (lvl_chg) begin
            pend_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (code != NONE) begin
                  state_q <= HOLD;
                  code_q  <= code;
                  timer_q <= '0;
               end
            end
            HOLD: begin
               if (code == NONE) begin
                  state_q <= IDLE;
                  timer_q <= '0;
               end else if (code != code_q) begin
                  code_q  <= code;
                  timer_q <= '0;
               end else if (timer_q == DLY_TC) begin
                  state_q <= REPEAT;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            REPEAT: begin
               if (code == NONE) begin
                  state_q <= IDLE;
                  timer_q <= '0;
               end else if (code != code_q) begin
                  state_q <= HOLD;
                  code_q  <= code;
                  timer_q <= '0;
               end else if (timer_q == RATE_TC) begin
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               timer_q <= '0;
            end
         endcase
      end
   end

   assign div_o  = div_q;
   assign valueF = val_q;
   assign pend_o = pend_q;
   assign upd_o  = upd_q;
endmodule
